// File: rtl/llmv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : llmv_pkg                                               |
// | Description : Shared fixed-point definitions for the datapath        |
// |               (Q16.16 type, fraction width, 32-bit saturation).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package llmv_pkg;

  localparam int FRAC_BITS = 16;

  typedef logic signed [31:0] q16_16_t;

  localparam q16_16_t Q16_MAX = 32'sh7FFF_FFFF;
  localparam q16_16_t Q16_MIN = 32'sh8000_0000;

  // Clamp a signed 64-bit intermediate into the Q16.16 range.
  function automatic q16_16_t sat_q16(input logic signed [63:0] v);
    if (v[63:31] == {33{v[63]}}) begin
      return q16_16_t'(v[31:0]);
    end else if (v[63]) begin
      return Q16_MIN;
    end else begin
      return Q16_MAX;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_isqrt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_isqrt                                              |
// | Description : Bit-serial non-restoring integer square root.          |
// |               48-bit radicand, 24-bit floor root, 24 iterations.     |
// |               done_o is high during the cycle whose closing edge     |
// |               writes the last root bit; root_o then holds steady.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_isqrt
  import llmv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [47:0] rad_i,
  output logic        done_o,
  output logic [23:0] root_o
);

  logic [47:0] rad_q;
  logic [27:0] rem_q;   // two's complement partial remainder
  logic [23:0] root_q;
  logic [4:0]  cnt_q;
  logic        busy_q;

  logic [27:0] w_rem_sh;
  logic [27:0] w_rem_nx;

  // One non-restoring step: bring down two radicand bits, then subtract
  // or add the trial term depending on the sign of the previous remainder.
  always_comb begin
    w_rem_sh = (rem_q << 2) | {26'd0, rad_q[47:46]};
    w_rem_nx = w_rem_sh;
    if (!rem_q[27]) begin
      w_rem_nx = w_rem_sh - {2'b00, root_q, 2'b01};
    end else begin
      w_rem_nx = w_rem_sh + {2'b00, root_q, 2'b11};
    end
  end

  // Iteration registers: load on start, then one root bit per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rad_q  <= rad_i;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rad_q  <= rad_q << 2;
      rem_q  <= w_rem_nx;
      root_q <= {root_q[22:0], ~w_rem_nx[27]};
      cnt_q  <= cnt_q + 5'd1;
      if (cnt_q == 5'd23) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_o = busy_q && (cnt_q == 5'd23);
  assign root_o = root_q;

endmodule
`default_nettype wire

// File: rtl/rmsnorm_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rmsnorm_stream                                         |
// | Description : Streaming RMS normalisation, y_i = w_i*x_i/rms(x).     |
// |               Buffers one D-element vector, then mean, sqrt,         |
// |               reciprocal and per-element scale, emitted as a stream. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rmsnorm_stream
  import llmv_pkg::*;
#(
  parameter int D   = 128,
  parameter int EPS = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic [31:0] in_weight_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o
);

  localparam int LOG2D = $clog2(D);
  localparam int ACC_W = 64 + LOG2D;
  localparam logic [LOG2D-1:0] CNT_LAST = LOG2D'(D - 1);

  typedef enum logic [2:0] {
    S_LOAD = 3'd0,
    S_MEAN = 3'd1,
    S_SQRT = 3'd2,
    S_DIV  = 3'd3,
    S_EMIT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [LOG2D-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic [31:0]      x_buf_q [D];
  logic [31:0]      w_buf_q [D];
  logic [23:0]      div_rem_q;
  logic [31:0]      inv_q;
  logic [5:0]       div_cnt_q;
  logic             issued_q;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic             out_last_q;

  logic               w_accept;
  logic [63:0]        w_x_ext;
  logic [63:0]        w_sq;
  logic [ACC_W-1:0]   w_ms_full;
  logic [31:0]        w_ms;
  logic [32:0]        w_v33;
  logic [31:0]        w_v;
  logic               w_sqrt_done;
  logic [23:0]        w_root;
  logic [24:0]        w_div_trial;
  logic               w_div_ge;
  logic [31:0]        w_ex;
  logic [31:0]        w_ew;
  logic signed [63:0] w_p1;
  logic signed [63:0] w_t;
  logic signed [95:0] w_p2;
  logic signed [63:0] w_y64;
  q16_16_t            w_y;
  logic               w_out_load;
  logic               w_issue;

  // ---------------- input side and mean of squares ----------------
  assign w_accept = in_valid_i && in_ready_q;
  assign w_x_ext  = {{32{in_data_i[31]}}, in_data_i};
  assign w_sq     = $signed(w_x_ext) * $signed(w_x_ext);

  assign w_ms_full = acc_q >> (LOG2D + FRAC_BITS);
  assign w_ms      = (|w_ms_full[ACC_W-1:32]) ? 32'hFFFF_FFFF : w_ms_full[31:0];
  assign w_v33     = {1'b0, w_ms} + 33'(EPS);
  assign w_v       = w_v33[32] ? 32'hFFFF_FFFF : w_v33[31:0];

  seq_isqrt u_isqrt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (state_q == S_MEAN),
    .rad_i   ({w_v, 16'd0}),
    .done_o  (w_sqrt_done),
    .root_o  (w_root)
  );

  // ---------------- restoring reciprocal 2^32 / r ----------------
  // The dividend is a single 1 followed by 32 zeros, so only the first
  // step brings down a 1. The leading quotient bit is always 0 because
  // r >= 256, so it is simply shifted out of the 32-bit register.
  assign w_div_trial = {div_rem_q, (div_cnt_q == 6'd0)};
  assign w_div_ge    = w_div_trial >= {1'b0, w_root};

  // ---------------- per-element scale ----------------
  assign w_ex  = x_buf_q[cnt_q];
  assign w_ew  = w_buf_q[cnt_q];
  assign w_p1  = $signed({{32{w_ex[31]}}, w_ex}) * $signed({32'd0, inv_q});
  assign w_t   = w_p1 >>> FRAC_BITS;
  assign w_p2  = $signed({{32{w_t[63]}}, w_t}) * $signed({{64{w_ew[31]}}, w_ew});
  assign w_y64 = 64'(w_p2 >>> FRAC_BITS);
  assign w_y   = sat_q16(w_y64);

  assign w_out_load = !out_valid_q || out_ready_i;
  assign w_issue    = (state_q == S_EMIT) && w_out_load && !issued_q;

  // Next-state logic for the load / compute / emit sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD: if (w_accept && (cnt_q == CNT_LAST)) state_d = S_MEAN;
      S_MEAN: state_d = S_SQRT;
      S_SQRT: if (w_sqrt_done) state_d = S_DIV;
      S_DIV:  if (div_cnt_q == 6'd32) state_d = S_EMIT;
      S_EMIT: if (out_valid_q && out_ready_i && out_last_q) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // State register, element counter, ready flag and square accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_LOAD;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == S_LOAD);
      if (w_accept) begin
        cnt_q <= cnt_q + LOG2D'(1);
        acc_q <= acc_q + {{(ACC_W-64){1'b0}}, w_sq};
      end else if (w_issue) begin
        cnt_q <= cnt_q + LOG2D'(1);
      end
      // The mean is consumed by the sqrt engine on this edge; start clean.
      if (state_q == S_MEAN) begin
        acc_q <= '0;
      end
    end
  end

  // Element buffers: written in arrival order, read by the emit counter.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      x_buf_q[cnt_q] <= in_data_i;
      w_buf_q[cnt_q] <= in_weight_i;
    end
  end

  // Reciprocal divider: cleared while the mean is formed, one bit per DIV cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_rem_q <= '0;
      inv_q     <= '0;
      div_cnt_q <= '0;
    end else if (state_q == S_MEAN) begin
      div_rem_q <= '0;
      inv_q     <= '0;
      div_cnt_q <= '0;
    end else if (state_q == S_DIV) begin
      div_rem_q <= w_div_ge ? 24'(w_div_trial - {1'b0, w_root}) : 24'(w_div_trial);
      inv_q     <= {inv_q[30:0], w_div_ge};
      div_cnt_q <= div_cnt_q + 6'd1;
    end
  end

  // Output register: refills whenever empty or drained, holds while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      issued_q    <= 1'b0;
    end else begin
      if (w_issue) begin
        out_valid_q <= 1'b1;
        out_data_q  <= w_y;
        out_last_q  <= (cnt_q == CNT_LAST);
        if (cnt_q == CNT_LAST) begin
          issued_q <= 1'b1;
        end
      end else if (w_out_load) begin
        out_valid_q <= 1'b0;
      end
      if ((state_q == S_EMIT) && (state_d == S_LOAD)) begin
        issued_q <= 1'b0;
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule
`default_nettype wire
